sram_nr1w_be: RTL and testbench

- Parametrised simulation SRAM: one write port with byte enables, NUM_READ independent read ports, configurable read latency.
- Successor to the single-read-port simulation SRAM; used by caches and register-file models that need multi-ported reads and partial writes.
- Read-during-write policy is selectable. Output pipeline and valid flags are reset. Memory contents are never cleared.

---
 rtl/sram_nr1w_be.sv | 139 +++++++++++++
 tb/tb_sram_nr1w_be.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_nr1w_be.sv
// Simulation SRAM with one byte-enabled write port and NUM_READ read ports.
// Optional SRAM_NR1W_BE_COLLISION_CNT_EN adds a saturating collision counter.
module sram_nr1w_be #(
    parameter int    DATA_WIDTH        = 32,
    parameter int    SIZE              = 1024,
    parameter int    NUM_READ          = 2,
    parameter int    READ_LATENCY      = 1,
    parameter string READ_DURING_WRITE = "NEW_DATA",
    localparam int   ADDR_WIDTH        = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int   NUM_BYTES         = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_READ-1:0]              read_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   read_addr,
    output logic [NUM_READ-1:0]              read_valid,
    output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
    input  logic                             write_en,
    input  logic [NUM_BYTES-1:0]             write_be,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            write_data
`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
    ,
    output logic [31:0]                      collision_count
`endif
);

    localparam int MODE =
        (READ_DURING_WRITE == "NEW_DATA")  ? 0 :
        (READ_DURING_WRITE == "OLD_DATA")  ? 1 :
        (READ_DURING_WRITE == "DONT_CARE") ? 2 : 3;

    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH+1)'(SIZE);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_WIDTH must be a multiple of 8");
    end
    if (NUM_READ < 1 || NUM_READ > 8) begin : g_bad_nr
        $error("NUM_READ must be 1..8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("READ_LATENCY must be 1..4");
    end
    if (MODE == 3) begin : g_bad_rdw
        $error("unknown READ_DURING_WRITE policy");
    end

    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic                  wr_ok;

    assign wr_ok = write_en && ({1'b0, write_addr} < SIZE_W);

    // Array is never cleared; reset only blocks the write on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && wr_ok) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (write_be[b]) begin
                    mem[write_addr][b*8 +: 8] <= write_data[b*8 +: 8];
                end
            end
        end
    end

`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
    logic [NUM_READ-1:0] coll;
`endif

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    in_rng;
        logic                    hit;
        logic [DATA_WIDTH-1:0]   stored;
        logic [READ_LATENCY-1:0] vld;
        logic [DATA_WIDTH-1:0]   dat [READ_LATENCY];

        assign addr   = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign in_rng = {1'b0, addr} < SIZE_W;
        assign hit    = write_en && (addr == write_addr);
        assign stored = in_rng ? mem[addr] : '0;

`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
        assign coll[p] = read_en[p] & hit;
`endif

        // Stage 0 freezes the word; later stages only delay it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= '0;
                for (int k = 0; k < READ_LATENCY; k++) begin
                    dat[k] <= '0;
                end
            end else begin
                vld[0] <= read_en[p];
                for (int k = 1; k < READ_LATENCY; k++) begin
                    vld[k] <= vld[k-1];
                    dat[k] <= dat[k-1];
                end
                if (read_en[p]) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (hit && in_rng && write_be[b] && MODE != 1) begin
                            dat[0][b*8 +: 8] <= (MODE == 2) ?
                                8'($random) : write_data[b*8 +: 8];
                        end else begin
                            dat[0][b*8 +: 8] <= stored[b*8 +: 8];
                        end
                    end
                end
            end
        end

        assign read_valid[p]                    = vld[READ_LATENCY-1];
        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = dat[READ_LATENCY-1];
    end

`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
    logic [3:0]  n_coll;
    logic [32:0] cc_sum;

    always_comb begin
        n_coll = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            n_coll = n_coll + 4'(coll[p]);
        end
    end

    assign cc_sum = {1'b0, collision_count} + 33'(n_coll);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_count <= '0;
        end else if (cc_sum[32]) begin
            collision_count <= '1;
        end else begin
            collision_count <= cc_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_sram_nr1w_be.sv
// Bench for sram_nr1w_be: three instances (L1 new-data, L1 old-data,
// L3 with SIZE=1000) checked against a model memory and scoreboard.
module tb_sram_nr1w_be;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    localparam int LAT [3] = '{1, 1, 3};
    localparam int SZ  [3] = '{1024, 1024, 1000};
    localparam int POL [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [1:0]  ren_s    [3];
    logic [19:0] raddr_s  [3];
    logic [1:0]  rvalid_s [3];
    logic [63:0] rdata_s  [3];
    logic        we_s     [3];
    logic [3:0]  be_s     [3];
    logic [9:0]  wa_s     [3];
    logic [31:0] wd_s     [3];
    logic [31:0] cc_s     [3];

    logic [31:0] mem_m [3][1024];
    int          cc_m  [3];
    exp_t        sbq   [6][$];

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    sram_nr1w_be #(
        .READ_LATENCY(1), .READ_DURING_WRITE("NEW_DATA")
    ) u_new (
        .clk(clk), .rst_n(rst_n),
        .read_en(ren_s[0]), .read_addr(raddr_s[0]),
        .read_valid(rvalid_s[0]), .read_data(rdata_s[0]),
        .write_en(we_s[0]), .write_be(be_s[0]),
        .write_addr(wa_s[0]), .write_data(wd_s[0])
`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
        , .collision_count(cc_s[0])
`endif
    );

    sram_nr1w_be #(
        .READ_LATENCY(1), .READ_DURING_WRITE("OLD_DATA")
    ) u_old (
        .clk(clk), .rst_n(rst_n),
        .read_en(ren_s[1]), .read_addr(raddr_s[1]),
        .read_valid(rvalid_s[1]), .read_data(rdata_s[1]),
        .write_en(we_s[1]), .write_be(be_s[1]),
        .write_addr(wa_s[1]), .write_data(wd_s[1])
`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
        , .collision_count(cc_s[1])
`endif
    );

    sram_nr1w_be #(
        .SIZE(1000), .READ_LATENCY(3), .READ_DURING_WRITE("NEW_DATA")
    ) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .read_en(ren_s[2]), .read_addr(raddr_s[2]),
        .read_valid(rvalid_s[2]), .read_data(rdata_s[2]),
        .write_en(we_s[2]), .write_be(be_s[2]),
        .write_addr(wa_s[2]), .write_data(wd_s[2])
`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
        , .collision_count(cc_s[2])
`endif
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear();
        for (int i = 0; i < 3; i++) begin
            ren_s[i] = '0; raddr_s[i] = '0; we_s[i] = 1'b0;
            be_s[i] = '0; wa_s[i] = '0; wd_s[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic issue(int i, logic [1:0] ren, logic [9:0] a0,
                         logic [9:0] a1, logic we, logic [3:0] be,
                         logic [9:0] wa, logic [31:0] wd);
        logic [9:0]  a;
        logic [31:0] e;
        ren_s[i] = ren; raddr_s[i] = {a1, a0};
        we_s[i] = we; be_s[i] = be; wa_s[i] = wa; wd_s[i] = wd;
        if (!rst_n) return;
        for (int p = 0; p < 2; p++) begin
            if (ren[p]) begin
                a = (p == 1) ? a1 : a0;
                e = (a < SZ[i]) ? mem_m[i][a] : 32'h0;
                if (a < SZ[i] && we && wa == a && POL[i] == 0) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) e[b*8 +: 8] = wd[b*8 +: 8];
                end
                if (we && wa == a) cc_m[i]++;
                sbq[i*2+p].push_back('{cnt + LAT[i], e});
            end
        end
        if (we && wa < SZ[i]) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[i][wa][b*8 +: 8] = wd[b*8 +: 8];
        end
    endtask

    task automatic wr(int i, logic [9:0] wa, logic [31:0] wd,
                      logic [3:0] be);
        issue(i, 2'b00, 10'd0, 10'd0, 1'b1, be, wa, wd);
    endtask

    task automatic rd(int i, logic [1:0] ren, logic [9:0] a0,
                      logic [9:0] a1);
        issue(i, ren, a0, a1, 1'b0, 4'h0, 10'd0, 32'h0);
    endtask

    function automatic logic [9:0] pick(int i);
        if (i == 2 && $urandom_range(7) == 0)
            return 10'(1000 + $urandom_range(23));
        return 10'($urandom_range(15));
    endfunction

    // Scoreboard: pops on every valid, flags early, late or stray results.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (rvalid_s[i][p] === 1'b1) begin
                    if (sbq[i*2+p].size() == 0) begin
                        check($sformatf("spurious_valid i%0d p%0d", i, p),
                              64'(rvalid_s[i][p]), 64'd0);
                    end else begin
                        e = sbq[i*2+p].pop_front();
                        check($sformatf("lat i%0d p%0d", i, p),
                              64'(cnt), 64'(e.due));
                        check($sformatf("data i%0d p%0d", i, p),
                              64'(rdata_s[i][p*32 +: 32]), 64'(e.data));
                    end
                end else if (sbq[i*2+p].size() != 0 &&
                             sbq[i*2+p][0].due <= cnt) begin
                    check($sformatf("missing_valid i%0d p%0d", i, p),
                          64'(rvalid_s[i][p]), 64'd1);
                    void'(sbq[i*2+p].pop_front());
                end
            end
        end
    end

    initial begin
        clear();
        for (int i = 0; i < 3; i++) cc_m[i] = 0;
        #3 rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid i%0d", i), 64'(rvalid_s[i]), 64'd0);
            check($sformatf("rst_data i%0d", i), rdata_s[i], 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // basic write then read, port 1 idle
        for (int i = 0; i < 3; i++) wr(i, 10'd5, 32'hDEADBEEF, 4'hF);
        tick();
        for (int i = 0; i < 3; i++) rd(i, 2'b01, 10'd5, 10'd0);
        tick();

        // byte enables
        wr(0, 10'd3, 32'h11223344, 4'hF);
        tick();
        wr(0, 10'd3, 32'hAABBCCDD, 4'b0101);
        tick();
        rd(0, 2'b11, 10'd3, 10'd3);
        tick();

        // collision on both ports, both policies
        wr(0, 10'd7, 32'h0, 4'hF);
        wr(1, 10'd7, 32'h0, 4'hF);
        tick();
        for (int i = 0; i < 2; i++)
            issue(i, 2'b11, 10'd7, 10'd7, 1'b1, 4'b0011, 10'd7, 32'hFFFFFFFF);
        tick();
`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
        check("ccnt new", 64'(cc_s[0]), 64'(cc_m[0]));
        check("ccnt old", 64'(cc_s[1]), 64'(cc_m[1]));
`endif
        for (int i = 0; i < 2; i++) rd(i, 2'b11, 10'd7, 10'd7);
        tick();

        // latency 3 back-to-back, write behind an in-flight read
        for (int a = 0; a < 3; a++) begin
            wr(2, 10'(a), 32'(10 + a), 4'hF);
            tick();
        end
        rd(2, 2'b01, 10'd0, 10'd0);
        tick();
        rd(2, 2'b01, 10'd1, 10'd0);
        tick();
        issue(2, 2'b01, 10'd2, 10'd0, 1'b1, 4'hF, 10'd1, 32'd99);
        tick();
        rd(2, 2'b10, 10'd0, 10'd1);
        tick();

        // out-of-range write and read
        wr(2, 10'd1000, 32'h12345678, 4'hF);
        tick();
        rd(2, 2'b11, 10'd1000, 10'd0);
        tick();
        rd(2, 2'b11, 10'd2, 10'd999);
        tick();
        repeat (4) tick();

        // reset with a read in flight and a write on the reset edge
        rd(2, 2'b01, 10'd0, 10'd0);
        tick();
        rst_n = 1'b0;
        for (int q = 0; q < 6; q++) sbq[q].delete();
        for (int i = 0; i < 3; i++) cc_m[i] = 0;
        wr(0, 10'd5, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        check("midrst_valid", 64'(rvalid_s[2]), 64'd0);
        check("midrst_data", rdata_s[2], 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear();
        repeat (5) tick();
        rd(2, 2'b01, 10'd0, 10'd0);
        rd(0, 2'b10, 10'd0, 10'd5);
        tick();
        repeat (4) tick();

        // random traffic over a small prefilled window
        for (int a = 0; a < 16; a++) begin
            for (int i = 0; i < 3; i++) wr(i, 10'(a), $urandom, 4'hF);
            tick();
        end
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++)
                issue(i, 2'($urandom), pick(i), pick(i),
                      1'($urandom), 4'($urandom), pick(i), $urandom);
            tick();
        end
        repeat (6) tick();
        @(negedge clk);
        for (int q = 0; q < 6; q++)
            check($sformatf("drain q%0d", q), 64'(sbq[q].size()), 64'd0);
`ifdef SRAM_NR1W_BE_COLLISION_CNT_EN
        for (int i = 0; i < 3; i++)
            check($sformatf("ccnt end i%0d", i), 64'(cc_s[i]), 64'(cc_m[i]));
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
